fu_issue_wb: RTL
================

// Module: fu_issue_wb
// PURPOSE
//  Issue/writeback stage wrapped around function_unit. Accepts one instruction
//  per valid/ready handshake, reads operands from an internal register file,
//  drives a/b/FS of function_unit, then captures op and V,C,N,Z. The result is
//  written back to the destination register and the status register.
//  Multi-cycle, non-pipelined: one instruction in flight.
// PARAMETERS
//  DW    8  data width; must match function_unit operand width
//  NREG  8  number of registers
//  AW    3  register address width, NREG == 2**AW
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  instr_valid  in   1   instruction present
//  instr_ready  out  1   stage can accept an instruction
//  instr_fs     in   4   function select passed to function_unit
//  instr_rd     in   AW  destination register
//  instr_ra     in   AW  operand A register
//  instr_rb     in   AW  operand B register
//  instr_imm_sel in  1   1: operand B = instr_imm; 0: operand B = reg[rb]
//  instr_imm    in   DW  immediate operand
//  fu_a         out  DW  to function_unit a
//  fu_b         out  DW  to function_unit b
//  fu_fs        out  4   to function_unit FS
//  fu_op        in   DW  from function_unit op
//  fu_v, fu_c, fu_n, fu_z  in  1 each  from function_unit flags
//  done         out  1   writeback-complete strobe
//  result       out  DW  last written-back value
//  flags        out  4   status register {V,C,N,Z}
//  dbg_addr     in   AW  register-file debug read address
//  dbg_data     out  DW  reg[dbg_addr], combinational
// BEHAVIOUR
//  - Reset: all registers, fu_a, fu_b, fu_fs, result, flags and done are 0.
//    State goes to IDLE. An assertion mid-instruction aborts it and no write occurs.
//  - FSM states and transitions:
//      IDLE -> READ  on instr_valid & instr_ready; latch fs, rd, ra, rb, imm_sel, imm
//      READ -> EXEC  register fu_a=reg[ra] and fu_b=imm_sel?imm:reg[rb]; fu_fs=fs
//      EXEC -> WB    sample fu_op and flags; write reg[rd], result and flags
//      WB   -> IDLE  unconditionally
//  - instr_ready = (state==IDLE). instr_valid is ignored in every other state.
//    The instruction fields need only be stable during the accept cycle.
//  - done = (state==WB). It is high for exactly 1 cycle, 3 cycles after the accept edge.
//    Throughput is 1 instruction per 4 cycles.
//  - fu_a, fu_b and fu_fs hold their values from READ until the next READ.
//  - Operands are read in READ, so an instruction with rd==ra or rd==rb sees the
//    old value. A new instruction accepted after done sees the new value.
//  - Flag update for shift/transfer-B ops (fs[3:2]==2'b11): only N and Z are
//    updated; V and C keep their previous values. All other ops update all four flags.
//  - All arithmetic is inside function_unit. This stage never modifies fu_op.
//  - dbg_data reflects a write from the cycle after the EXEC->WB edge.
// CONFIGURATION
//  ZERO_REG_EN defined: reg[0] always reads 0 (operands and dbg_data), and writes
//    with rd==0 are discarded. result and flags are still updated.
//  ZERO_REG_EN undefined: reg[0] is an ordinary register.
// TESTING
//  1. Reset mid-op:
//     - accept an instruction, assert rst_n=0 during EXEC
//     - all registers read 0, done=0, instr_ready=1 after release, no write
//  2. Load immediate and add:
//     - fs=1100, imm_sel=1, imm=0x7F, rd=1
//     - then fs=1100, imm=0x01, rd=2
//     - then fs=0010 (A+B), ra=1, rb=2, rd=3
//     - expect reg3=0x80, flags=1010 (V=1, N=1)
//  3. Subtract to zero:
//     - reg1=0x05, reg2=0x05, fs=0101 (A-B), rd=4
//     - expect reg4=0x00, flags C=1, Z=1, N=0
//  4. Shift preserves V/C:
//     - after test 2 (V=1, C=0), fs=1110 (shl B), imm_sel=1, imm=0x81, rd=5
//     - expect reg5=0x02, flags=1000
//  5. Handshake:
//     - hold instr_valid=1 continuously
//     - accepts exactly every 4th cycle, done 3 cycles after each accept
//     - rd==ra uses the old operand
//  6. ZERO_REG_EN:
//     - write 0x55 to rd=0
//     - dbg_data(0)=0x00 with the macro defined; 0x55 without it

Source files
------------

// File: rtl/fu_issue_wb.sv
// Issue/writeback stage around an external function_unit: one instruction in flight,
// IDLE->READ->EXEC->WB. Optional macro ZERO_REG_EN makes reg[0] a hard-wired zero.
module fu_issue_wb #(
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_fs,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_ra,
    input  logic [AW-1:0] instr_rb,
    input  logic          instr_imm_sel,
    input  logic [DW-1:0] instr_imm,
    output logic [DW-1:0] fu_a,
    output logic [DW-1:0] fu_b,
    output logic [3:0]    fu_fs,
    input  logic [DW-1:0] fu_op,
    input  logic          fu_v,
    input  logic          fu_c,
    input  logic          fu_n,
    input  logic          fu_z,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [3:0]    flags,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t        state_q;
    logic          ready_q;
    logic          done_q;
    logic [3:0]    fs_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] ra_q;
    logic [AW-1:0] rb_q;
    logic          imm_sel_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] fu_a_q;
    logic [DW-1:0] fu_b_q;
    logic [3:0]    fu_fs_q;
    logic [DW-1:0] result_q;
    logic [3:0]    flags_q;
    logic [DW-1:0] regs_q [NREG];

    logic [3:0]    flags_d;
    logic          wr_en_d;

    function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] addr);
`ifdef ZERO_REG_EN
        return (addr == '0) ? '0 : regs_q[addr];
`else
        return regs_q[addr];
`endif
    endfunction

    // Shift/transfer-B ops leave V and C untouched.
    always_comb begin
        flags_d = {fu_v, fu_c, fu_n, fu_z};
        if (fu_fs_q[3:2] == 2'b11)
            flags_d = {flags_q[3:2], fu_n, fu_z};
    end

    always_comb begin
`ifdef ZERO_REG_EN
        wr_en_d = (rd_q != '0);
`else
        wr_en_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            fs_q      <= '0;
            rd_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
            fu_a_q    <= '0;
            fu_b_q    <= '0;
            fu_fs_q   <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            for (int unsigned i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        fs_q      <= instr_fs;
                        rd_q      <= instr_rd;
                        ra_q      <= instr_ra;
                        rb_q      <= instr_rb;
                        imm_sel_q <= instr_imm_sel;
                        imm_q     <= instr_imm;
                        ready_q   <= 1'b0;
                        state_q   <= READ;
                    end
                end
                READ: begin
                    fu_a_q  <= rf_read(ra_q);
                    fu_b_q  <= imm_sel_q ? imm_q : rf_read(rb_q);
                    fu_fs_q <= fs_q;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (wr_en_d)
                        regs_q[rd_q] <= fu_op;
                    result_q <= fu_op;
                    flags_q  <= flags_d;
                    done_q   <= 1'b1;
                    state_q  <= WB;
                end
                WB: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign done        = done_q;
    assign fu_a        = fu_a_q;
    assign fu_b        = fu_b_q;
    assign fu_fs       = fu_fs_q;
    assign result      = result_q;
    assign flags       = flags_q;
    assign dbg_data    = rf_read(dbg_addr);

endmodule
